// File: rtl/csr_exec_unit.sv
// CSR execute stage: Zicsr decode, read-modify-write and in-flight write tracking.
// Build option CSR_EXEC_FWD_EN: forward in-flight writes instead of raising hazard.
module csr_exec_unit #(
    parameter int XLEN      = 32,
    parameter int FWD_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_in_valid,
    input  logic [2:0]      i_in_funct3,
    input  logic [11:0]     i_in_addr,
    input  logic [4:0]      i_in_rs1_idx,
    input  logic [XLEN-1:0] i_in_rs1_val,
    input  logic [1:0]      i_priv,
    output logic [11:0]     o_file_raddr,
    input  logic [XLEN-1:0] i_file_rdata,
    output logic            o_in_ready,
    output logic            o_res_valid,
    output logic [XLEN-1:0] o_res_old,
    output logic            o_res_wr_en,
    output logic [11:0]     o_res_wr_addr,
    output logic [XLEN-1:0] o_res_wr_data,
    output logic            o_res_illegal,
    output logic            o_hazard
);

    logic                 r_res_valid;
    logic [XLEN-1:0]      r_res_old;
    logic                 r_res_wr_en;
    logic [11:0]          r_res_wr_addr;
    logic [XLEN-1:0]      r_res_wr_data;
    logic                 r_res_illegal;

    logic [FWD_DEPTH-1:0] r_trk_v;
    logic [11:0]          r_trk_a [FWD_DEPTH];
    logic [XLEN-1:0]      r_trk_d [FWD_DEPTH];

    logic                 w_op_valid;
    logic                 w_wr_intent;
    logic                 w_illegal;
    logic                 w_hazard;
    logic                 w_accept;
    logic [XLEN-1:0]      w_src;
    logic [XLEN-1:0]      w_old;
    logic [XLEN-1:0]      w_new;

    assign w_op_valid  = i_in_valid && (i_in_funct3[1:0] != 2'b00);
    assign w_src       = i_in_funct3[2] ? {{(XLEN-5){1'b0}}, i_in_rs1_idx} : i_in_rs1_val;
    assign w_wr_intent = (i_in_funct3[1:0] == 2'b01) || (i_in_rs1_idx != 5'd0);
    assign w_illegal   = (i_in_addr[9:8] > i_priv) ||
                         (w_wr_intent && (i_in_addr[11:10] == 2'b11));

`ifdef CSR_EXEC_FWD_EN
    // Scan oldest to youngest so the youngest matching write ends up in w_old.
    always_comb begin
        w_old = i_file_rdata;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (r_trk_v[i] && (r_trk_a[i] == i_in_addr)) w_old = r_trk_d[i];
        end
        if (r_res_valid && r_res_wr_en && (r_res_wr_addr == i_in_addr)) w_old = r_res_wr_data;
    end
    assign w_hazard = 1'b0;
`else
    logic w_match;
    always_comb begin
        w_match = r_res_valid && r_res_wr_en && (r_res_wr_addr == i_in_addr);
        for (int i = 0; i < FWD_DEPTH; i++) begin
            if (r_trk_v[i] && (r_trk_a[i] == i_in_addr)) w_match = 1'b1;
        end
    end
    assign w_old    = i_file_rdata;
    assign w_hazard = !rst && w_op_valid && w_match;
`endif

    always_comb begin
        case (i_in_funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            default: w_new = w_old & ~w_src;
        endcase
    end

    assign o_in_ready = !rst && !i_stall && !w_hazard && !i_flush;
    assign w_accept   = o_in_ready && w_op_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_old     <= '0;
            r_res_wr_en   <= 1'b0;
            r_res_wr_addr <= '0;
            r_res_wr_data <= '0;
            r_res_illegal <= 1'b0;
            r_trk_v       <= '0;
            for (int i = 0; i < FWD_DEPTH; i++) begin
                r_trk_a[i] <= '0;
                r_trk_d[i] <= '0;
            end
        end else if (i_flush) begin
            r_res_valid   <= 1'b0;
            r_res_wr_en   <= 1'b0;
            r_res_illegal <= 1'b0;
            r_trk_v       <= '0;
        end else if (!i_stall) begin
            // The result register's write retires into slot 0; the oldest slot drops.
            r_trk_v[0] <= r_res_valid && r_res_wr_en;
            r_trk_a[0] <= r_res_wr_addr;
            r_trk_d[0] <= r_res_wr_data;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                r_trk_v[i] <= r_trk_v[i-1];
                r_trk_a[i] <= r_trk_a[i-1];
                r_trk_d[i] <= r_trk_d[i-1];
            end
            if (w_accept) begin
                r_res_valid   <= 1'b1;
                r_res_wr_addr <= i_in_addr;
                r_res_illegal <= w_illegal;
                r_res_wr_en   <= !w_illegal && w_wr_intent;
                r_res_old     <= w_illegal ? '0 : w_old;
                r_res_wr_data <= w_illegal ? '0 : w_new;
            end else begin
                r_res_valid   <= 1'b0;
                r_res_wr_en   <= 1'b0;
                r_res_illegal <= 1'b0;
            end
        end
    end

    assign o_file_raddr  = i_in_addr;
    assign o_res_valid   = r_res_valid;
    assign o_res_old     = r_res_old;
    assign o_res_wr_en   = r_res_wr_en;
    assign o_res_wr_addr = r_res_wr_addr;
    assign o_res_wr_data = r_res_wr_data;
    assign o_res_illegal = r_res_illegal;
    assign o_hazard      = w_hazard;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: per-cycle model comparison plus directed literal checks.
// Expectations follow CSR_EXEC_FWD_EN when it is defined for the build.
module tb_csr_exec_unit;
    localparam int XLEN = 32;
    localparam int FWD_DEPTH = 2;

    logic            clk;
    logic            rst;
    logic            stall, flush, in_valid;
    logic [2:0]      in_funct3;
    logic [11:0]     in_addr;
    logic [4:0]      in_rs1_idx;
    logic [XLEN-1:0] in_rs1_val;
    logic [1:0]      priv;
    logic [XLEN-1:0] file_rdata;
    logic [11:0]     o_file_raddr;
    logic            o_in_ready, o_res_valid, o_res_wr_en, o_res_illegal, o_hazard;
    logic [XLEN-1:0] o_res_old, o_res_wr_data;
    logic [11:0]     o_res_wr_addr;

    int total = 0;
    int bad = 0;

    csr_exec_unit #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH)) dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_in_valid(in_valid),
        .i_in_funct3(in_funct3), .i_in_addr(in_addr), .i_in_rs1_idx(in_rs1_idx),
        .i_in_rs1_val(in_rs1_val), .i_priv(priv), .o_file_raddr(o_file_raddr),
        .i_file_rdata(file_rdata), .o_in_ready(o_in_ready), .o_res_valid(o_res_valid),
        .o_res_old(o_res_old), .o_res_wr_en(o_res_wr_en), .o_res_wr_addr(o_res_wr_addr),
        .o_res_wr_data(o_res_wr_data), .o_res_illegal(o_res_illegal), .o_hazard(o_hazard)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the result register plus the list of writes still in flight, youngest first.
    typedef struct {
        bit              v;
        logic [11:0]     a;
        logic [XLEN-1:0] d;
    } wr_t;

    wr_t             inflight[$];
    bit              started = 0;
    bit              m_valid = 0, m_wen = 0, m_ill = 0;
    logic [XLEN-1:0] m_old = '0, m_wdata = '0;
    logic [11:0]     m_waddr = '0;

    function automatic bit m_op_valid();
        return in_valid && (in_funct3[1:0] != 2'b00);
    endfunction

    function automatic bit model_hazard();
`ifdef CSR_EXEC_FWD_EN
        return 1'b0;
`else
        if (rst || !m_op_valid()) return 1'b0;
        if (m_valid && m_wen && m_waddr == in_addr) return 1'b1;
        foreach (inflight[i]) if (inflight[i].v && inflight[i].a == in_addr) return 1'b1;
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        return !rst && !stall && !flush && !model_hazard();
    endfunction

    function automatic logic [XLEN-1:0] model_old();
`ifdef CSR_EXEC_FWD_EN
        if (m_valid && m_wen && m_waddr == in_addr) return m_wdata;
        foreach (inflight[i]) if (inflight[i].v && inflight[i].a == in_addr) return inflight[i].d;
`endif
        return file_rdata;
    endfunction

    task automatic clear_inflight();
        inflight.delete();
        for (int i = 0; i < FWD_DEPTH; i++) inflight.push_back('{1'b0, 12'h0, '0});
    endtask

    initial clear_inflight();

    always @(posedge clk) begin
        bit              acc, wi, ill;
        logic [XLEN-1:0] src, old, nw;
        started = 1;
        acc = model_ready() && m_op_valid();
        src = in_funct3[2] ? XLEN'(in_rs1_idx) : in_rs1_val;
        old = model_old();
        case (in_funct3[1:0])
            2'b01:   nw = src;
            2'b10:   nw = old | src;
            default: nw = old & ~src;
        endcase
        wi  = (in_funct3[1:0] == 2'b01) || (in_rs1_idx != 0);
        ill = (in_addr[9:8] > priv) || (wi && in_addr[11:10] == 2'b11);
        if (rst) begin
            m_valid = 0; m_wen = 0; m_ill = 0; m_old = '0; m_wdata = '0; m_waddr = '0;
            clear_inflight();
        end else if (flush) begin
            m_valid = 0; m_wen = 0; m_ill = 0;
            clear_inflight();
        end else if (!stall) begin
            inflight.push_front('{m_valid && m_wen, m_waddr, m_wdata});
            void'(inflight.pop_back());
            if (acc) begin
                m_valid = 1; m_waddr = in_addr; m_ill = ill;
                m_wen   = !ill && wi;
                m_old   = ill ? '0 : old;
                m_wdata = ill ? '0 : nw;
            end else begin
                m_valid = 0; m_wen = 0; m_ill = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", o_in_ready, model_ready());
            chk("hazard", o_hazard, model_hazard());
            chk("raddr", o_file_raddr, in_addr);
            chk("res_valid", o_res_valid, m_valid);
            chk("res_wr_en", o_res_wr_en, m_wen);
            chk("res_illegal", o_res_illegal, m_ill);
            if (m_valid) begin
                chk("res_old", o_res_old, m_old);
                chk("res_wr_addr", o_res_wr_addr, m_waddr);
            end
            if (m_wen) chk("res_wr_data", o_res_wr_data, m_wdata);
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                         input logic [XLEN-1:0] v, output int stalls);
        in_valid = 1'b1; in_funct3 = f3; in_addr = a; in_rs1_idx = idx; in_rs1_val = v;
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_in_ready) begin
                @(posedge clk); #1;
                return;
            end
            stalls++;
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL issue_bound actual=%0d stalls required=accept", stalls);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_funct3 = 3'b000;
        @(posedge clk); #1;
    endtask

    int st;

    initial begin
        rst = 1; stall = 0; flush = 0; in_valid = 0; in_funct3 = 0; in_addr = 0;
        in_rs1_idx = 0; in_rs1_val = 0; priv = 2'b11; file_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_res_valid, 0);
        chk("rst_wr_en", o_res_wr_en, 0);
        chk("rst_illegal", o_res_illegal, 0);
        chk("rst_ready", o_in_ready, 0);
        chk("rst_hazard", o_hazard, 0);
        rst = 0;
        @(posedge clk); #1;

        // CSRRW 0x340
        file_rdata = 0;
        issue(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, st);
        chk("rw_valid", o_res_valid, 1);
        chk("rw_old", o_res_old, 0);
        chk("rw_wr_en", o_res_wr_en, 1);
        chk("rw_data", o_res_wr_data, 32'hDEADBEEF);

        // Back-to-back CSRRS 0x300
        file_rdata = 32'h1;
        issue(3'b010, 12'h300, 5'd2, 32'h8, st);
        chk("rs1_old", o_res_old, 32'h1);
        chk("rs1_data", o_res_wr_data, 32'h9);
        issue(3'b010, 12'h300, 5'd3, 32'h2, st);
`ifdef CSR_EXEC_FWD_EN
        chk("rs2_stalls", st, 0);
        chk("rs2_old", o_res_old, 32'h9);
        chk("rs2_data", o_res_wr_data, 32'hB);
`else
        chk("rs2_stalls", st, 3);
        chk("rs2_old", o_res_old, 32'h1);
        chk("rs2_data", o_res_wr_data, 32'h3);
`endif

        // Read-only CSR 0xC00
        file_rdata = 32'h1234;
        issue(3'b011, 12'hC00, 5'd0, 32'hFF, st);
        chk("ro_rd_wr_en", o_res_wr_en, 0);
        chk("ro_rd_illegal", o_res_illegal, 0);
        chk("ro_rd_old", o_res_old, 32'h1234);
        issue(3'b001, 12'hC00, 5'd4, 32'h5, st);
        chk("ro_wr_illegal", o_res_illegal, 1);
        chk("ro_wr_wr_en", o_res_wr_en, 0);
        chk("ro_wr_old", o_res_old, 0);

        // Privilege
        priv = 2'b00;
        issue(3'b010, 12'h300, 5'd1, 32'h0, st);
        chk("priv_u_illegal", o_res_illegal, 1);
        priv = 2'b11;
        issue(3'b010, 12'h300, 5'd1, 32'h0, st);
        chk("priv_m_illegal", o_res_illegal, 0);
        idle();

        // Immediate forms at S level
        priv = 2'b01; file_rdata = 32'h10;
        issue(3'b110, 12'h105, 5'd5, 32'hFFFF, st);
        chk("rsi_old", o_res_old, 32'h10);
        chk("rsi_data", o_res_wr_data, 32'h15);
        issue(3'b111, 12'h105, 5'd4, 32'hFFFF, st);
`ifdef CSR_EXEC_FWD_EN
        chk("rci_old", o_res_old, 32'h15);
        chk("rci_data", o_res_wr_data, 32'h11);
`else
        chk("rci_old", o_res_old, 32'h10);
        chk("rci_data", o_res_wr_data, 32'h10);
`endif
        priv = 2'b00;
        issue(3'b101, 12'h105, 5'd31, 32'h0, st);
        chk("rwi_u_illegal", o_res_illegal, 1);
        priv = 2'b11;

        // No-op funct3 is a bubble
        issue(3'b100, 12'h340, 5'd1, 32'h1, st);
        chk("noop_valid", o_res_valid, 0);
        idle();

        // Stall holds the result
        issue(3'b001, 12'h342, 5'd1, 32'hA5, st);
        in_valid = 0; stall = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_ready", o_in_ready, 0);
        chk("stall_valid", o_res_valid, 1);
        chk("stall_data", o_res_wr_data, 32'hA5);
        stall = 0;
        idle();
        repeat (3) idle();

        // Stall + flush with a valid op
        issue(3'b001, 12'h305, 5'd1, 32'h55, st);
        in_valid = 1; in_funct3 = 3'b001; in_addr = 12'h306; in_rs1_idx = 5'd1;
        in_rs1_val = 32'h1; stall = 1; flush = 1;
        @(posedge clk); #1;
        chk("flush_valid", o_res_valid, 0);
        chk("flush_wr_en", o_res_wr_en, 0);
        stall = 0; flush = 0; file_rdata = 32'h77;
        issue(3'b010, 12'h305, 5'd0, 32'h0, st);
        chk("flush_rd_stalls", st, 0);
        chk("flush_rd_old", o_res_old, 32'h77);
        idle();

        // CSRRW 0x341 then CSRRS 0x341
        file_rdata = 0;
        issue(3'b001, 12'h341, 5'd1, 32'h5, st);
        file_rdata = 32'h10;
        issue(3'b010, 12'h341, 5'd1, 32'h0, st);
`ifdef CSR_EXEC_FWD_EN
        chk("haz_stalls", st, 0);
        chk("haz_old", o_res_old, 32'h5);
`else
        chk("haz_stalls", st, 3);
        chk("haz_old", o_res_old, 32'h10);
`endif
        chk("haz_data", o_res_wr_data, o_res_old);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Parametrised CSR execute stage that replaces the fixed 32-bit CSR handler datapath. It decodes Zicsr operations, performs the read-modify-write against the CSR file's combinational read port, and forwards from a configurable-depth tracker of in-flight CSR writes. It also enforces the write-suppression, read-only and privilege rules. It sits between decode and the writeback-side CSR file write port.

## Interface
Parameters:
- XLEN, 32, CSR data width (32 or 64)
- FWD_DEPTH, 2, in-flight CSR write entries tracked (1..4); the entry leaving the oldest slot is already visible in the CSR file

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold all state; input not accepted
- flush  in  1  kill result register and all tracker entries
- in_valid  in  1  CSR instruction present
- in_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 = no-op
- in_addr  in  12  CSR address
- in_rs1_idx  in  5  rs1 index / zimm
- in_rs1_val  in  XLEN  forwarded rs1 value
- priv  in  2  current privilege (00 U, 01 S, 11 M)
- file_raddr  out  12  = in_addr, combinational
- file_rdata  in  XLEN  CSR file read data for file_raddr
- in_ready  out  1  instruction accepted this cycle
- res_valid  out  1  result register valid
- res_old  out  XLEN  pre-write CSR value (to rd)
- res_wr_en  out  1  CSR write to perform
- res_wr_addr  out  12  CSR write address
- res_wr_data  out  XLEN  CSR write data
- res_illegal  out  1  illegal-instruction trap request
- hazard  out  1  stall request (CSR_EXEC_FWD_EN undefined only; else tied 0)

## Operation
- Decode: op valid when in_valid and funct3 not in {000,100}; otherwise treated as a bubble.
- src = in_rs1_val for RW/RS/RC; zimm = zero-extended in_rs1_idx for the I forms.
- old = forwarded value (see below), else file_rdata.
- new: RW/RWI = src; RS/RSI = old | src; RC/RCI = old & ~src.
- Write intent: always for RW/RWI; for the other forms only when in_rs1_idx != 0.
- Illegal if in_addr[9:8] > priv, or write intent with in_addr[11:10] == 2'b11.
  - Illegal: res_illegal=1, res_wr_en=0, res_old=0.
- Tracker: FWD_DEPTH slots {valid, addr, data}.
  - Slot 0 is loaded from the result register's write (valid = res_valid & res_wr_en) on each non-stalled cycle; the other slots shift toward FWD_DEPTH-1, and the oldest entry drops.
  - Forwarding compares in_addr against the result register first, then slots 0..FWD_DEPTH-1. The youngest valid match wins.

## Timing
- Latency 1: accepted at edge N → res_* valid during cycle N+1.
- in_ready = !stall & !hazard & !flush.
- Not accepted and not stalled: res_valid goes 0 (bubble).
- Stall: result register and tracker hold; outputs unchanged.
- Flush (sync): res_valid, res_wr_en, res_illegal and all tracker valid bits go 0 next edge.
  - Flush wins over stall and over simultaneous acceptance.
- Reset: every res_* output 0, tracker cleared, hazard 0, in_ready 0 during reset.
- Simultaneous read and write of the same CSR: the forwarded in-flight value is used; the same-cycle CSR file write is not seen.
- Back-to-back RS to the same address: the second sees the first's new value with 0 stall cycles when CSR_EXEC_FWD_EN is defined.

## Configuration
- CSR_EXEC_FWD_EN defined: forwarding mux active; hazard tied 0.
- CSR_EXEC_FWD_EN undefined: no forwarding; old = file_rdata always.
  - hazard=1 while a valid op's in_addr matches the result register or any valid tracker entry.
  - The op waits until the matching entry drains; up to FWD_DEPTH+1 stall cycles.

## Test plan
- Reset, then CSRRW 0x340 with rs1_val 0xDEADBEEF, file_rdata 0 → next cycle res_valid=1, res_old=0, res_wr_en=1, res_wr_data=0xDEADBEEF.
- CSRRS 0x300 with src 0x8, then CSRRS 0x300 with src 0x2, back-to-back, file_rdata 0x1 (FWD_EN) → second res_old=0x9, res_wr_data=0xB, no stall.
- CSRRC with in_rs1_idx=0 on 0xC00 → res_wr_en=0, res_illegal=0; CSRRW on 0xC00 → res_illegal=1, res_wr_en=0.
- priv=00, CSRRS 0x300 → res_illegal=1; priv=11, same op → legal.
- Valid op with stall and flush both high → next cycle res_valid=0 and all tracker entries empty; a following read of the same address returns file_rdata.
- FWD_EN undefined, FWD_DEPTH=2, CSRRW 0x341 followed by CSRRS 0x341 → hazard=1 for 3 cycles, then accepted with res_old=file_rdata.
